dmem_responder: RTL and testbench

Memory-side responder for the datapath's data-memory port. Accepts one load or store request at a time over a valid/ready handshake, models a configurable number of wait states, performs the access on an internal word array, and returns the result over a second valid/ready handshake. It sits between the MEM stage and the data storage, and is the slave end of the datapath's data-memory request interface.

---
 rtl/dmem_responder.sv | 115 +++++++++++
 tb/tb_dmem_responder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder with programmable
// wait states. Requests are latched at accept, the array access happens after
// WAIT idle cycles, and the response is held until the requester takes it.

module dmem_responder #(
    parameter int unsigned DSIZE = 16,
    parameter int unsigned ASIZE = 16,
    parameter int unsigned DEPTH = 256,
    parameter int unsigned WAIT  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [ASIZE-1:0] req_addr,
    input  logic [DSIZE-1:0] req_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [DSIZE-1:0] rsp_rdata,
    output logic             rsp_err,
    output logic             busy
);

    // Index width into the word array; DEPTH is a power of two.
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e           state_q, state_d;
    logic [3:0]       cnt_q;
    logic             we_q;
    logic [ASIZE-1:0] addr_q;
    logic [DSIZE-1:0] wdata_q;
    logic [DSIZE-1:0] rdata_q;
    logic             err_q;
    logic [DSIZE-1:0] mem [DEPTH];

    logic accept;
    logic access;
    logic in_range;

    assign accept   = req_valid && req_ready;
    assign access   = (state_q == StWait) && (cnt_q == 4'd0);
    // Any address bit above the index range set means the word does not exist.
    assign in_range = ((addr_q >> AW) == '0);

    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StWait;
            StWait:  if (cnt_q == 4'd0) state_d = StResp;
            StResp:  if (rsp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Handshake and status outputs decoded from registered state.
    always_comb begin
        req_ready = rst && (state_q == StIdle);
        rsp_valid = (state_q == StResp);
        busy      = (state_q != StIdle);
    end

    // Request latch, wait counter and response registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                cnt_q   <= 4'(WAIT);
            end else if ((state_q == StWait) && (cnt_q != 4'd0)) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (access) begin
                if (in_range) begin
                    rdata_q <= we_q ? wdata_q : mem[addr_q[AW-1:0]];
                    err_q   <= 1'b0;
                end else begin
                    rdata_q <= '0;
                    err_q   <= 1'b1;
                end
            end
        end
    end

    // Word array write; never cleared, and suppressed while reset is asserted.
    always_ff @(posedge clk) begin
        if (rst && access && in_range && we_q) begin
            mem[addr_q[AW-1:0]] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a WAIT=2 instance for the main scenarios
// and a WAIT=0 instance for minimum latency and back-to-back spacing.

module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;

    logic        req_valid, req_we, rsp_ready;
    logic [15:0] req_addr, req_wdata;
    logic        req_ready, rsp_valid, rsp_err, busy;
    logic [15:0] rsp_rdata;

    logic        z_req_valid, z_req_we, z_rsp_ready;
    logic [15:0] z_req_addr, z_req_wdata;
    logic        z_req_ready, z_rsp_valid, z_rsp_err, z_busy;
    logic [15:0] z_rsp_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DSIZE(16), .ASIZE(16), .DEPTH(256), .WAIT(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    dmem_responder #(.DSIZE(16), .ASIZE(16), .DEPTH(256), .WAIT(0)) dut0 (
        .clk       (clk),
        .rst       (rst),
        .req_valid (z_req_valid),
        .req_ready (z_req_ready),
        .req_we    (z_req_we),
        .req_addr  (z_req_addr),
        .req_wdata (z_req_wdata),
        .rsp_valid (z_rsp_valid),
        .rsp_ready (z_rsp_ready),
        .rsp_rdata (z_rsp_rdata),
        .rsp_err   (z_rsp_err),
        .busy      (z_busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request on the selected instance; returns once rsp_valid is seen
    // with lat = cycles from the accept edge, or lat = -1 on timeout.
    task automatic issue(input bit sel, input bit we, input logic [15:0] addr,
                         input logic [15:0] data, output int lat);
        int  n;
        bit  seen;
        if (sel) begin
            z_req_valid = 1'b1; z_req_we = we; z_req_addr = addr; z_req_wdata = data;
        end else begin
            req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = data;
        end
        n = 0;
        while (!(sel ? z_req_ready : req_ready) && n < 20) begin
            tick();
            n++;
        end
        tick();
        if (sel) z_req_valid = 1'b0;
        else     req_valid   = 1'b0;
        lat  = -1;
        seen = 1'b0;
        n    = 0;
        while (!seen && n < 20) begin
            tick();
            n++;
            if (sel ? z_rsp_valid : rsp_valid) begin
                seen = 1'b1;
                lat  = n;
            end
        end
    endtask

    initial begin
        int lat;
        int prev;
        int acc;

        rst = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0; req_wdata = 16'h0;
        rsp_ready = 1'b1;
        z_req_valid = 1'b0; z_req_we = 1'b0; z_req_addr = 16'h0; z_req_wdata = 16'h0;
        z_rsp_ready = 1'b1;

        // Reset held with a request pending.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
            chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
            chk("rst_busy", {31'b0, busy}, 32'd0);
            chk("rst_rdata", {16'b0, rsp_rdata}, 32'h0000);
        end
        req_valid = 1'b0;
        rst = 1'b1;
        tick();
        chk("post_rst_ready", {31'b0, req_ready}, 32'd1);

        // Store then load.
        issue(1'b0, 1'b1, 16'h0010, 16'hBEEF, lat);
        chk("st_lat", 32'(lat), 32'd3);
        chk("st_rdata", {16'b0, rsp_rdata}, 32'hBEEF);
        chk("st_err", {31'b0, rsp_err}, 32'd0);
        chk("st_busy", {31'b0, busy}, 32'd1);
        tick();
        chk("st_done_valid", {31'b0, rsp_valid}, 32'd0);
        chk("st_done_ready", {31'b0, req_ready}, 32'd1);

        issue(1'b0, 1'b0, 16'h0010, 16'h0000, lat);
        chk("ld_lat", 32'(lat), 32'd3);
        chk("ld_rdata", {16'b0, rsp_rdata}, 32'hBEEF);
        tick();

        // Backpressure: response held for 5 cycles.
        rsp_ready = 1'b0;
        issue(1'b0, 1'b0, 16'h0010, 16'h0000, lat);
        chk("bp_lat", 32'(lat), 32'd3);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", {31'b0, rsp_valid}, 32'd1);
            chk("bp_rdata", {16'b0, rsp_rdata}, 32'hBEEF);
            chk("bp_req_ready", {31'b0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        tick();
        chk("bp_release_valid", {31'b0, rsp_valid}, 32'd0);
        chk("bp_release_ready", {31'b0, req_ready}, 32'd1);
        chk("bp_keep_rdata", {16'b0, rsp_rdata}, 32'hBEEF);

        // Out of range store must not alias onto word 0.
        issue(1'b0, 1'b1, 16'h0000, 16'h1357, lat);
        tick();
        issue(1'b0, 1'b1, 16'h0100, 16'hAAAA, lat);
        chk("oor_lat", 32'(lat), 32'd3);
        chk("oor_err", {31'b0, rsp_err}, 32'd1);
        chk("oor_rdata", {16'b0, rsp_rdata}, 32'h0000);
        tick();
        issue(1'b0, 1'b0, 16'h0000, 16'h0000, lat);
        chk("alias_rdata", {16'b0, rsp_rdata}, 32'h1357);
        chk("alias_err", {31'b0, rsp_err}, 32'd0);
        tick();

        // Reset during WAIT drops the store.
        issue(1'b0, 1'b1, 16'h0020, 16'h5555, lat);
        tick();
        req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0020; req_wdata = 16'h1234;
        tick();
        req_valid = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("abort_valid", {31'b0, rsp_valid}, 32'd0);
        end
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("abort_after_valid", {31'b0, rsp_valid}, 32'd0);
            chk("abort_after_busy", {31'b0, busy}, 32'd0);
        end
        issue(1'b0, 1'b0, 16'h0020, 16'h0000, lat);
        chk("abort_ld_rdata", {16'b0, rsp_rdata}, 32'h5555);
        tick();

        // WAIT=0 instance: single-cycle latency.
        issue(1'b1, 1'b1, 16'h0005, 16'h4242, lat);
        chk("w0_st_lat", 32'(lat), 32'd1);
        tick();
        issue(1'b1, 1'b0, 16'h0005, 16'h0000, lat);
        chk("w0_ld_lat", 32'(lat), 32'd1);
        chk("w0_ld_rdata", {16'b0, z_rsp_rdata}, 32'h4242);
        tick();

        // Back-to-back requests every 3 cycles.
        z_req_we = 1'b0; z_req_addr = 16'h0005; z_req_valid = 1'b1;
        prev = -1;
        acc  = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (z_req_ready) begin
                if (prev >= 0) chk("w0_gap", 32'(cyc - prev), 32'd3);
                prev = cyc;
                acc++;
            end
            tick();
        end
        z_req_valid = 1'b0;
        chk("w0_accepts", 32'(acc), 32'd4);
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
